// File: rtl/mips_datapath_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_datapath_memory_responder_if
// Purpose  : Request/response bundle between the MEM pipeline stage (master)
//            and the data-memory responder (slave).
// Signals  : req_valid/req_ready   request handshake
//            req_write             1 = store, 0 = load
//            req_size              0 byte, 1 half, 2/3 word
//            req_signed            sign-extend byte/half loads
//            req_addr, req_wdata   byte address and store data
//            rsp_valid             one-cycle response pulse
//            rsp_rdata, rsp_error  extended load data / fault flag
//            stall                 pipeline hold request
// Revision : 1.0 - initial release
// ============================================================================
interface mips_datapath_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        stall;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, stall
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, stall
  );
endinterface
`default_nettype wire

// File: rtl/mips_datapath_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : mips_datapath_memory_responder
// Purpose  : Word-organised data memory answering one MEM-stage load/store at
//            a time. A request is captured in IDLE, held for WAIT_STATES
//            cycles, performed, and answered with a single rsp_valid pulse.
//            Misaligned or out-of-range requests are answered after one cycle
//            with rsp_error set and no memory access.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset (memory is not cleared)
//            bus    slave side of mips_datapath_memory_responder_if
// Revision : 1.0 - initial release
// ============================================================================
module mips_datapath_memory_responder #(
  parameter int ADDR_L      = 64,
  parameter int ADDR_W      = $clog2(ADDR_L),
  parameter int WAIT_STATES = 2
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  mips_datapath_memory_responder_if.slave  bus
);

  localparam logic [1:0] C_S_IDLE = 2'd0;
  localparam logic [1:0] C_S_WAIT = 2'd1;
  localparam logic [1:0] C_S_RESP = 2'd2;
  localparam logic [2:0] C_WAIT   = 3'(WAIT_STATES);
  localparam bit         C_NOWAIT = (WAIT_STATES == 0);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [ADDR_L];

  // Effective request: live bus fields while IDLE (zero-wait access happens on
  // the accept edge), captured fields afterwards so bus churn is ignored.
  logic              w_idle;
  logic              w_accept;
  logic              w_eff_write;
  logic [1:0]        w_eff_size;
  logic              w_eff_signed;
  logic [31:0]       w_eff_addr;
  logic [31:0]       w_eff_wdata;
  logic              w_err;
  logic              w_do_access;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_idle       = (state_q == C_S_IDLE);
  assign w_accept     = w_idle & bus.req_valid;
  assign w_eff_write  = w_idle ? bus.req_write  : write_q;
  assign w_eff_size   = w_idle ? bus.req_size   : size_q;
  assign w_eff_signed = w_idle ? bus.req_signed : signed_q;
  assign w_eff_addr   = w_idle ? bus.req_addr   : addr_q;
  assign w_eff_wdata  = w_idle ? bus.req_wdata  : wdata_q;

  always_comb begin
    w_err = 1'b0;
    if (w_eff_size == 2'd1 && w_eff_addr[0])
      w_err = 1'b1;
    if (w_eff_size[1] && (w_eff_addr[1:0] != 2'b00))
      w_err = 1'b1;
    if ({2'b00, w_eff_addr[31:2]} >= 32'(ADDR_L))
      w_err = 1'b1;
  end

  assign w_do_access = (w_accept & ~w_err & C_NOWAIT) |
                       ((state_q == C_S_WAIT) & (cnt_q == 3'd1));

  assign w_idx  = w_eff_addr[ADDR_W+1:2];
  assign w_word = mem_q[w_idx];
  assign w_byte = w_word[{w_eff_addr[1:0], 3'b000} +: 8];
  assign w_half = w_eff_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = w_word;
    case (w_eff_size)
      2'd0:    w_load = {{24{w_eff_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{w_eff_signed & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Read-modify-write merge: only the addressed lanes take store data.
  always_comb begin
    w_merged = w_word;
    case (w_eff_size)
      2'd0: w_merged[{w_eff_addr[1:0], 3'b000} +: 8] = w_eff_wdata[7:0];
      2'd1: begin
        if (w_eff_addr[1]) w_merged[31:16] = w_eff_wdata[15:0];
        else               w_merged[15:0]  = w_eff_wdata[15:0];
      end
      default: w_merged = w_eff_wdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= C_S_IDLE;
      cnt_q    <= 3'd0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Storage has no reset; rst_n gates the write so a store pending when reset
  // hits is dropped.
  always_ff @(posedge clk) begin
    if (w_do_access && w_eff_write && rst_n)
      mem_q[w_idx] <= w_merged;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      C_S_IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (w_err) begin
            state_d = C_S_RESP;
            rdata_d = 32'd0;
            error_d = 1'b1;
          end else if (C_NOWAIT) begin
            state_d = C_S_RESP;
            rdata_d = bus.req_write ? 32'd0 : w_load;
            error_d = 1'b0;
          end else begin
            state_d = C_S_WAIT;
            cnt_d   = C_WAIT;
          end
        end
      end
      C_S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = C_S_RESP;
          rdata_d = write_q ? 32'd0 : w_load;
          error_d = 1'b0;
        end
      end
      C_S_RESP: state_d = C_S_IDLE;
      default:  state_d = C_S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = w_idle;
    bus.rsp_valid = (state_q == C_S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_error = error_q;
    bus.stall     = w_accept | (state_q == C_S_WAIT);
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_datapath_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_datapath_memory_responder
// Purpose  : Directed vector bench for the data-memory responder; one
//            instance with two wait states, one with none.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_datapath_memory_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_datapath_memory_responder_if bus2 ();
  mips_datapath_memory_responder_if bus0 ();

  mips_datapath_memory_responder #(.ADDR_L(64), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  mips_datapath_memory_responder #(.ADDR_L(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, logic [1:0] sz, bit sg, logic [31:0] a,
                              logic [31:0] d, logic [31:0] er, bit e);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_err = e; v.exp_lat = e ? 1 : 3;
    return v;
  endfunction

  // One request on the 2-wait-state instance; the bus is scrambled right
  // after the accept edge.
  task automatic do_req(input vec_t v, input string nm);
    int lat = 0;
    int st  = 0;
    bit got = 0;
    logic [31:0] rd = '0;
    logic er = 1'b0, rdy = 1'b0, stl = 1'b0;
    @(negedge clk);
    bus2.req_write  = v.wr;
    bus2.req_size   = v.sz;
    bus2.req_signed = v.sg;
    bus2.req_addr   = v.addr;
    bus2.req_wdata  = v.wdata;
    bus2.req_valid  = 1'b1;
    #1;
    chk({nm, " ready"}, 32'(bus2.req_ready), 32'd1);
    chk({nm, " stall_acc"}, 32'(bus2.stall), 32'd1);
    @(posedge clk);
    #1;
    bus2.req_valid  = 1'b0;
    bus2.req_addr   = $urandom;
    bus2.req_wdata  = $urandom;
    bus2.req_size   = 2'($urandom_range(0, 3));
    bus2.req_signed = ~v.sg;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus2.rsp_valid) begin
        got = 1; rd = bus2.rsp_rdata; er = bus2.rsp_error;
        rdy = bus2.req_ready; stl = bus2.stall;
      end else if (bus2.stall) st++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, " rdata"}, rd, v.exp_rdata);
    chk({nm, " error"}, 32'(er), 32'(v.exp_err));
    chk({nm, " ready_resp"}, 32'(rdy), 32'd0);
    chk({nm, " stall_resp"}, 32'(stl), 32'd0);
    chk({nm, " stall_wait"}, 32'(st), 32'(v.exp_lat - 1));
    @(negedge clk);
    chk({nm, " pulse_end"}, 32'(bus2.rsp_valid), 32'd0);
  endtask

  vec_t vecs[20];
  int pulses;

  initial begin
    bus2.req_valid = 0; bus2.req_write = 0; bus2.req_size = 0; bus2.req_signed = 0;
    bus2.req_addr = 0; bus2.req_wdata = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_size = 0; bus0.req_signed = 0;
    bus0.req_addr = 0; bus0.req_wdata = 0;

    vecs[0]  = mk(1, 2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    vecs[1]  = mk(0, 2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    vecs[2]  = mk(1, 2, 0, 32'h20,  32'h0,        32'h0,        0);
    vecs[3]  = mk(1, 0, 0, 32'h22,  32'hAAAAAA80, 32'h0,        0);
    vecs[4]  = mk(0, 2, 0, 32'h20,  32'h0,        32'h00800000, 0);
    vecs[5]  = mk(0, 0, 1, 32'h22,  32'h0,        32'hFFFFFF80, 0);
    vecs[6]  = mk(0, 0, 0, 32'h22,  32'h0,        32'h00000080, 0);
    vecs[7]  = mk(0, 1, 1, 32'h22,  32'h0,        32'h00000080, 0);
    vecs[8]  = mk(0, 2, 0, 32'h13,  32'h0,        32'h0,        1);
    vecs[9]  = mk(1, 1, 0, 32'h21,  32'hFFFFFFFF, 32'h0,        1);
    vecs[10] = mk(0, 2, 0, 32'h20,  32'h0,        32'h00800000, 0);
    vecs[11] = mk(0, 2, 0, 32'h100, 32'h0,        32'h0,        1);
    vecs[12] = mk(1, 2, 0, 32'h24,  32'h11111111, 32'h0,        0);
    vecs[13] = mk(1, 1, 0, 32'h26,  32'hBEEFCAFE, 32'h0,        0);
    vecs[14] = mk(0, 2, 0, 32'h24,  32'h0,        32'hCAFE1111, 0);
    vecs[15] = mk(0, 1, 1, 32'h26,  32'h0,        32'hFFFFCAFE, 0);
    vecs[16] = mk(0, 1, 0, 32'h24,  32'h0,        32'h00001111, 0);
    vecs[17] = mk(0, 0, 1, 32'h25,  32'h0,        32'h00000011, 0);
    vecs[18] = mk(0, 3, 0, 32'h24,  32'h0,        32'hCAFE1111, 0);
    vecs[19] = mk(1, 2, 0, 32'h08,  32'h0,        32'h0,        0);

    // Reset state
    #2;
    chk("rst ready", 32'(bus2.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("rst rdata", bus2.rsp_rdata, 32'd0);
    chk("rst error", 32'(bus2.rsp_error), 32'd0);
    chk("rst stall_lo", 32'(bus2.stall), 32'd0);
    bus2.req_valid = 1'b1;
    #1;
    chk("rst stall_hi", 32'(bus2.stall), 32'd1);
    bus2.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      do_req(vecs[i], $sformatf("vec%0d", i));

    // Zero-wait instance, request held continuously: stores to words 0..3
    @(negedge clk);
    bus0.req_write = 1'b1;
    bus0.req_size  = 2'd2;
    bus0.req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("ws0 ready%0d", k), 32'(bus0.req_ready), 32'(k % 2 == 0));
      chk($sformatf("ws0 rsp%0d", k), 32'(bus0.rsp_valid), 32'(k % 2 == 1));
      chk($sformatf("ws0 stall%0d", k), 32'(bus0.stall), 32'(k % 2 == 0));
      if (k % 2 == 0) begin
        bus0.req_addr  = 32'((k / 2) * 4);
        bus0.req_wdata = 32'hA0A00000 | 32'(k / 2);
      end
    end
    bus0.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus0.req_write = 1'b0;
      bus0.req_addr  = 32'(i * 4);
      bus0.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus0.req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("ws0 rd_valid%0d", i), 32'(bus0.rsp_valid), 32'd1);
      chk($sformatf("ws0 rd_data%0d", i), bus0.rsp_rdata, 32'hA0A00000 | 32'(i));
    end

    // Reset one cycle after accepting a store; the store must be dropped
    @(negedge clk);
    bus2.req_write = 1'b1; bus2.req_size = 2'd2; bus2.req_signed = 1'b0;
    bus2.req_addr = 32'h08; bus2.req_wdata = 32'h12345678; bus2.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst ready", 32'(bus2.req_ready), 32'd1);
    chk("mid_rst rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("mid_rst stall", 32'(bus2.stall), 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus2.rsp_valid) pulses++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus2.rsp_valid) pulses++;
    end
    chk("mid_rst pulses", 32'(pulses), 32'd0);
    do_req(mk(0, 2, 0, 32'h08, 32'h0, 32'h0, 0), "mid_rst load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
